rf_exec_ctrl: RTL and testbench

//  Initiator side of the reg_file read/write interface: a multi-cycle execute controller.

---
 rtl/rf_exec_pkg.sv | 54 +++++
 rtl/rf_exec_alu.sv | 51 +++++
 rtl/rf_exec_ctrl.sv | 126 ++++++++++++
 tb/tb_rf_exec_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_exec_pkg.sv
// Shared types, default widths and instruction field helpers for the reg_file execute controller.
// Instruction layout: {op[3:0], rd, rs1, rs2}; the LDI immediate is {rs1, rs2}.
package rf_exec_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 4;
  localparam int MAX_INSTR_W = 64;
  localparam int MAX_FIELD_W = 32;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_MOV = 4'd6,
    OP_LDI = 4'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  function automatic logic [3:0] instr_op(input logic [MAX_INSTR_W-1:0] instr, input int addr_w);
    logic [MAX_INSTR_W-1:0] sh;
    sh = instr >> (3 * addr_w);
    return sh[3:0];
  endfunction

  // idx selects the register field: 0 = rs2, 1 = rs1, 2 = rd
  function automatic logic [MAX_FIELD_W-1:0] instr_field(input logic [MAX_INSTR_W-1:0] instr,
                                                         input int addr_w, input int idx);
    logic [MAX_INSTR_W-1:0] sh;
    logic [MAX_INSTR_W-1:0] mask;
    sh   = instr >> (idx * addr_w);
    mask = (MAX_INSTR_W'(1) << addr_w) - MAX_INSTR_W'(1);
    sh   = sh & mask;
    return sh[MAX_FIELD_W-1:0];
  endfunction

  function automatic logic [MAX_FIELD_W-1:0] instr_imm(input logic [MAX_INSTR_W-1:0] instr,
                                                       input int addr_w);
    logic [MAX_INSTR_W-1:0] mask;
    logic [MAX_INSTR_W-1:0] v;
    mask = (MAX_INSTR_W'(1) << (2 * addr_w)) - MAX_INSTR_W'(1);
    v    = instr & mask;
    return v[MAX_FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/rf_exec_alu.sv
// Combinational ALU for the execute controller; carry is the raw carry/borrow of ADD/SUB.
// Define RF_EXEC_SAT_EN to clamp ADD to all-ones on overflow and SUB to zero on borrow.
module rf_exec_alu
  import rf_exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        carry = sum[DATA_W];
`ifdef RF_EXEC_SAT_EN
        result = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
        result = sum[DATA_W-1:0];
`endif
      end
      OP_SUB: begin
        carry = diff[DATA_W];
`ifdef RF_EXEC_SAT_EN
        result = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
        result = diff[DATA_W-1:0];
`endif
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rf_exec_ctrl.sv
// Multi-cycle execute controller driving a reg_file: IDLE -> READ -> EXEC -> WB, one instr per 4 cycles.
// Optional build macro RF_EXEC_SAT_EN selects saturating ADD/SUB inside rf_exec_alu.
module rf_exec_ctrl
  import rf_exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  nRESET,
  input  logic [4+3*ADDR_W-1:0] instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [ADDR_W-1:0]     RA1,
  output logic [ADDR_W-1:0]     RA2,
  input  logic [DATA_W-1:0]     RD1,
  input  logic [DATA_W-1:0]     RD2,
  output logic [ADDR_W-1:0]     WA,
  output logic [DATA_W-1:0]     ALUResult,
  output logic                  write_enable,
  output logic                  done,
  output logic                  flag_z,
  output logic                  flag_c
);

  localparam int INSTR_W = 4 + 3 * ADDR_W;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_READ = READ;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_WB   = WB;

  logic [1:0]         state_reg, state_next;
  logic [INSTR_W-1:0] instr_reg;
  logic [ADDR_W-1:0]  ra1_reg, ra2_reg, wa_reg;
  logic [DATA_W-1:0]  a_reg, b_reg, result_reg;
  logic               carry_reg, flag_z_reg, flag_c_reg;

  logic [3:0]         op_cur;
  logic [ADDR_W-1:0]  rd_cur, rs1_in, rs2_in;
  logic [DATA_W-1:0]  imm_cur, alu_result;
  logic               alu_carry, op_is_nop;

  assign op_cur    = instr_op(MAX_INSTR_W'(instr_reg), ADDR_W);
  assign rd_cur    = ADDR_W'(instr_field(MAX_INSTR_W'(instr_reg), ADDR_W, 2));
  assign imm_cur   = DATA_W'(instr_imm(MAX_INSTR_W'(instr_reg), ADDR_W));
  assign rs1_in    = ADDR_W'(instr_field(MAX_INSTR_W'(instr), ADDR_W, 1));
  assign rs2_in    = ADDR_W'(instr_field(MAX_INSTR_W'(instr), ADDR_W, 0));
  assign op_is_nop = (op_cur == OP_NOP) || (op_cur > OP_LDI);

  rf_exec_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_cur),
    .a      (a_reg),
    .b      (b_reg),
    .imm    (imm_cur),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (instr_valid) state_next = ST_READ;
      ST_READ: state_next = ST_EXEC;
      ST_EXEC: state_next = op_is_nop ? ST_IDLE : ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_reg  <= ST_IDLE;
      instr_reg  <= '0;
      ra1_reg    <= '0;
      ra2_reg    <= '0;
      wa_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      flag_z_reg <= 1'b0;
      flag_c_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_reg <= instr;
            ra1_reg   <= rs1_in;
            ra2_reg   <= rs2_in;
          end
        end
        ST_READ: begin
          a_reg <= RD1;
          b_reg <= RD2;
        end
        ST_EXEC: begin
          // NOPs leave the visible write port untouched
          if (!op_is_nop) begin
            result_reg <= alu_result;
            wa_reg     <= rd_cur;
            carry_reg  <= alu_carry;
          end
        end
        ST_WB: begin
          flag_z_reg <= (result_reg == '0);
          flag_c_reg <= carry_reg;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset removes them immediately
  assign instr_ready  = (state_reg == ST_IDLE);
  assign write_enable = (state_reg == ST_WB);
  assign done         = (state_reg == ST_WB) || ((state_reg == ST_EXEC) && op_is_nop);
  assign RA1          = ra1_reg;
  assign RA2          = ra2_reg;
  assign WA           = wa_reg;
  assign ALUResult    = result_reg;
  assign flag_z       = flag_z_reg;
  assign flag_c       = flag_c_reg;

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Scoreboard bench for rf_exec_ctrl with a behavioural 16x8 register file.
// Build with RF_EXEC_SAT_EN defined to check the saturating ADD/SUB variant.
module tb_rf_exec_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int IW = 4 + 3 * AW;
`ifdef RF_EXEC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nRESET = 1'b0;
  logic [IW-1:0] instr = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [AW-1:0] RA1, RA2, WA;
  logic [DW-1:0] RD1, RD2, ALUResult;
  logic          write_enable, done, flag_z, flag_c;

  logic [DW-1:0] rf [16];
  logic          rf_clr = 1'b1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         nop;
    logic [3:0] wa;
    logic [7:0] res;
    bit         z;
    bit         c;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  assign RD1 = rf[RA1];
  assign RD2 = rf[RA2];

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (write_enable) begin
      rf[WA] <= ALUResult;
    end
  end

  rf_exec_ctrl dut (
    .clk          (clk),
    .nRESET       (nRESET),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .RA1          (RA1),
    .RA2          (RA2),
    .RD1          (RD1),
    .RD2          (RD2),
    .WA           (WA),
    .ALUResult    (ALUResult),
    .write_enable (write_enable),
    .done         (done),
    .flag_z       (flag_z),
    .flag_c       (flag_c)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops on every done, checks flags one cycle after each writeback
  always @(negedge clk) begin : mon
    exp_t e;
    static bit   pend_flags = 1'b0;
    static exp_t pend;
    if (!nRESET) begin
      pend_flags = 1'b0;
    end else begin
      if (pend_flags) begin
        chk("flag_z", 32'(flag_z), 32'(pend.z));
        chk("flag_c", 32'(flag_c), 32'(pend.c));
        pend_flags = 1'b0;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 WA=%0d we=%0b, expected no done", WA, write_enable);
        end else begin
          e = sbq.pop_front();
          if (e.nop) begin
            chk("nop_we", 32'(write_enable), 32'd0);
            $display("[TB] nop done, we=%0b", write_enable);
          end else begin
            chk("wb_we", 32'(write_enable), 32'd1);
            chk("wb_wa", 32'(WA), 32'(e.wa));
            chk("wb_result", 32'(ALUResult), 32'(e.res));
            $display("[TB] wb WA=%0d ALUResult=%0d we=%0b (exp WA=%0d res=%0d)",
                     WA, ALUResult, write_enable, e.wa, e.res);
            pend       = e;
            pend_flags = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_ready_timeout: got instr_ready=0, expected 1 within 20 cycles", tag);
    end
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] res, input bit c);
    exp_t e;
    e.nop = !(op >= 4'd1 && op <= 4'd7);
    e.wa  = rd;
    e.res = res;
    e.z   = (res == 8'd0);
    e.c   = c;
    sbq.push_back(e);
  endtask

  // Returns one time unit after the accepting edge, i.e. inside the READ cycle
  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [7:0] res, input bit c);
    wait_ready("issue");
    instr       = {op, rd, rs1, rs2};
    instr_valid = 1'b1;
    push_exp(op, rd, res, c);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int accepts;
    int n;
    instr       = '1;
    instr_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ra1", 32'(RA1), 32'd0);
    chk("rst_ra2", 32'(RA2), 32'd0);
    chk("rst_wa", 32'(WA), 32'd0);
    chk("rst_alu", 32'(ALUResult), 32'd0);
    chk("rst_fz", 32'(flag_z), 32'd0);
    chk("rst_fc", 32'(flag_c), 32'd0);
    rf_clr      = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    @(negedge clk);
    nRESET = 1'b1;

    issue(4'd7, 4'd1, 4'd0, 4'd7, 8'd7, 1'b0);
    issue(4'd7, 4'd2, 4'd0, 4'd5, 8'd5, 1'b0);
    issue(4'd1, 4'd3, 4'd1, 4'd2, 8'd12, 1'b0);
    chk("read_ra1", 32'(RA1), 32'd1);
    chk("read_ra2", 32'(RA2), 32'd2);
    issue(4'd6, 4'd4, 4'd3, 4'd0, 8'd12, 1'b0);

    issue(4'd7, 4'd1, 4'hC, 4'h8, 8'd200, 1'b0);
    issue(4'd7, 4'd2, 4'h6, 4'h4, 8'd100, 1'b0);
    issue(4'd1, 4'd5, 4'd1, 4'd2, SAT ? 8'd255 : 8'd44, 1'b1);
    issue(4'd2, 4'd6, 4'd2, 4'd1, SAT ? 8'd0 : 8'd156, 1'b1);
    issue(4'd2, 4'd7, 4'd1, 4'd2, 8'd100, 1'b0);
    issue(4'd3, 4'd8, 4'd1, 4'd2, 8'd64, 1'b0);
    issue(4'd4, 4'd9, 4'd1, 4'd2, 8'd236, 1'b0);
    issue(4'd5, 4'd10, 4'd1, 4'd1, 8'd0, 1'b0);
    issue(4'd7, 4'd11, 4'h9, 4'hC, 8'd156, 1'b0);
    issue(4'd1, 4'd12, 4'd11, 4'd2, SAT ? 8'd255 : 8'd0, 1'b1);

    issue(4'd0, 4'd13, 4'd1, 4'd2, 8'd0, 1'b0);
    issue(4'd12, 4'd13, 4'd1, 4'd2, 8'd0, 1'b0);

    // instr_valid while busy must be ignored
    issue(4'd7, 4'd13, 4'h3, 4'h3, 8'h33, 1'b0);
    instr       = {4'd7, 4'd14, 4'h5, 4'h5};
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_ready", 32'(instr_ready), 32'd0);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_r13", 32'(rf[13]), 32'h33);
    chk("busy_r14", 32'(rf[14]), 32'h0);

    // valid held high: one accept per 4 cycles
    for (int i = 0; i < 4; i++) push_exp(4'd7, 4'd15, 8'h2A, 1'b0);
    wait_ready("hold");
    instr       = {4'd7, 4'd15, 4'h2, 4'hA};
    instr_valid = 1'b1;
    accepts     = 0;
    for (int i = 0; i < 16; i++) begin
      if (instr_ready && instr_valid) accepts++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("hold_accepts", 32'(accepts), 32'd4);
    repeat (2) @(negedge clk);
    chk("hold_r15", 32'(rf[15]), 32'h2A);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    // Reset during WB: write must not land
    issue(4'd7, 4'd14, 4'h7, 4'h7, 8'h77, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!write_enable && n < 10);
    chk("midrst_reach_wb", 32'(write_enable), 32'd1);
    #2;
    nRESET = 1'b0;
    #1;
    chk("midrst_we", 32'(write_enable), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_r14", 32'(rf[14]), 32'h0);
    nRESET = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    chk("post_rst_alu", 32'(ALUResult), 32'd0);
    chk("post_rst_wa", 32'(WA), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
